// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared segment constants for the hex seven-segment controller
package seg7_pkg;

  localparam int SEG_W = 7;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

  // Active-high gfedcba patterns, indexed by nibble value (entry 0 is rightmost)
  localparam logic [15:0][SEG_W-1:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/seg7_hex_decode.sv
// rtl/seg7_hex_decode.sv - nibble to seven-segment pattern with blanking and polarity
module seg7_hex_decode
  import seg7_pkg::*;
#(
  parameter int ACTIVE_LOW = 1
) (
  input  logic [3:0]       nibble,
  input  logic             blank,
  output logic [SEG_W-1:0] seg
);

  logic [SEG_W-1:0] lit;

  always_comb begin
    lit = blank ? SEG_BLANK : SEG_TABLE[nibble];
    seg = (ACTIVE_LOW != 0) ? ~lit : lit;
  end

endmodule

// File: rtl/seg7_display_ctrl.sv
// rtl/seg7_display_ctrl.sv - write-masked hex display with zero suppression, blink and scan
module seg7_display_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int ACTIVE_LOW = 1,
  parameter int SCAN_DIV   = 1000,
  parameter int BLINK_DIV  = 500000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        wr_en,
  input  logic [4*NUM_DIGITS-1:0]     wr_data,
  input  logic [NUM_DIGITS-1:0]       wr_mask,
  input  logic                        lz_suppress,
  input  logic [NUM_DIGITS-1:0]       blink_mask,
  output logic                        wr_ack,
  output logic [SEG_W*NUM_DIGITS-1:0] seg_o,
  output logic [SEG_W-1:0]            seg_mux_o,
  output logic [NUM_DIGITS-1:0]       dig_sel_o
);

  localparam int SCAN_W  = $clog2(SCAN_DIV);
  localparam int BLINK_W = $clog2(BLINK_DIV);
  localparam logic [SEG_W-1:0] SEG_ZERO = (ACTIVE_LOW != 0) ? ~SEG_TABLE[0] : SEG_TABLE[0];

  logic [4*NUM_DIGITS-1:0]              value_q;
  logic [BLINK_W-1:0]                   blink_cnt;
  logic                                 blink_phase;
  logic [SCAN_W-1:0]                    scan_cnt;
  logic                                 scan_wrap;
  logic [NUM_DIGITS-1:0]                sel_next;
  logic [NUM_DIGITS-1:0]                blank;
  logic                                 zero_run;
  logic [NUM_DIGITS-1:0][SEG_W-1:0]     pattern;
  logic [SEG_W-1:0]                     mux_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
      wr_ack  <= 1'b0;
    end else begin
      wr_ack <= wr_en;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (wr_en && wr_mask[i]) value_q[4*i +: 4] <= wr_data[4*i +: 4];
      end
    end
  end

  // A digit is a leading zero when it and every more-significant digit are zero
  always_comb begin
    zero_run = 1'b1;
    blank    = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run & (value_q[4*i +: 4] == 4'h0);
      blank[i] = (lz_suppress && (i > 0) && zero_run) || (!blink_phase && blink_mask[i]);
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    seg7_hex_decode #(.ACTIVE_LOW(ACTIVE_LOW)) u_dec (
      .nibble (value_q[4*g +: 4]),
      .blank  (blank[g]),
      .seg    (pattern[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // The shift pair degenerates to a hold when there is a single digit
  always_comb begin
    scan_wrap = (scan_cnt == SCAN_W'(SCAN_DIV - 1));
    sel_next  = scan_wrap ? ((dig_sel_o << 1) | (dig_sel_o >> (NUM_DIGITS - 1))) : dig_sel_o;
    mux_next  = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (sel_next[i]) mux_next = mux_next | pattern[i];
    end
  end

  // seg_mux_o is loaded from the digit about to be selected so both registers move together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt  <= '0;
      dig_sel_o <= NUM_DIGITS'(1);
      seg_o     <= {NUM_DIGITS{SEG_ZERO}};
      seg_mux_o <= SEG_ZERO;
    end else begin
      scan_cnt  <= scan_wrap ? '0 : scan_cnt + 1'b1;
      dig_sel_o <= sel_next;
      seg_o     <= pattern;
      seg_mux_o <= mux_next;
    end
  end

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// tb/tb_seg7_display_ctrl.sv - scoreboard bench for seg7_display_ctrl
module tb_seg7_display_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [31:0] wr_data;
  logic [7:0]  wr_mask;
  logic        lz;
  logic [7:0]  blink_mask;
  logic        wr_ack;
  logic [55:0] seg_o;
  logic [6:0]  seg_mux;
  logic [7:0]  dig_sel;

  logic        b_wr_en;
  logic [15:0] b_wr_data;
  logic [3:0]  b_wr_mask;
  logic        b_lz;
  logic [3:0]  b_blink_mask;
  logic        b_wr_ack;
  logic [27:0] b_seg;
  logic [6:0]  b_mux;
  logic [3:0]  b_sel;

  int checks = 0;
  int errors = 0;
  logic [55:0] exp_q[$];
  logic        ack_d;

  always #5 clk = ~clk;

  seg7_display_ctrl #(.NUM_DIGITS(8), .ACTIVE_LOW(1), .SCAN_DIV(3), .BLINK_DIV(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .wr_mask(wr_mask),
    .lz_suppress(lz), .blink_mask(blink_mask), .wr_ack(wr_ack), .seg_o(seg_o),
    .seg_mux_o(seg_mux), .dig_sel_o(dig_sel)
  );

  seg7_display_ctrl #(.NUM_DIGITS(4), .ACTIVE_LOW(0), .SCAN_DIV(2), .BLINK_DIV(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .wr_en(b_wr_en), .wr_data(b_wr_data), .wr_mask(b_wr_mask),
    .lz_suppress(b_lz), .blink_mask(b_blink_mask), .wr_ack(b_wr_ack), .seg_o(b_seg),
    .seg_mux_o(b_mux), .dig_sel_o(b_sel)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [55:0] pk8(input logic [6:0] d7, d6, d5, d4, d3, d2, d1, d0);
    return {d7, d6, d5, d4, d3, d2, d1, d0};
  endfunction

  // Caller is positioned on a negedge; consecutive calls give back-to-back writes
  task automatic do_write(input logic [31:0] data, input logic [7:0] mask, input logic [55:0] exp);
    wr_en   = 1'b1;
    wr_data = data;
    wr_mask = mask;
    exp_q.push_back(exp);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    chk("sb_drain", 64'(exp_q.size()), 64'd0);
  endtask

  // Each ack marks a write whose decoded result appears on seg_o one cycle later
  initial begin
    ack_d = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        ack_d = 1'b0;
      end else begin
        if (ack_d) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected_ack actual=1 required=0");
          end else begin
            chk("sb_seg_o", seg_o, exp_q.pop_front());
          end
        end
        ack_d = wr_ack;
      end
    end
  end

  logic [6:0] bs0 [16];
  logic [6:0] bs1 [16];
  logic [6:0] mux_tab [8];
  logic [7:0] prev_sel;
  int         k;
  bit         found;

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_data = '0; wr_mask = '0; lz = 1'b0; blink_mask = '0;
    b_wr_en = 1'b0; b_wr_data = '0; b_wr_mask = '0; b_lz = 1'b0; b_blink_mask = '0;
    mux_tab = '{7'h79, 7'h24, 7'h30, 7'h19, 7'h40, 7'h40, 7'h40, 7'h40};
    repeat (3) @(negedge clk);
    chk("rst_seg_o", seg_o, {8{7'h40}});
    chk("rst_seg_mux", seg_mux, 7'h40);
    chk("rst_dig_sel", dig_sel, 8'h01);
    chk("rst_wr_ack", wr_ack, 1'b0);
    chk("rst_b_seg", b_seg, {4{7'h3F}});
    chk("rst_b_sel", b_sel, 4'h1);
    rst_n = 1'b1;
    @(negedge clk);

    do_write(32'h12345678, 8'hFF, pk8(7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00));
    do_write(32'hFFFFFFFF, 8'h01, pk8(7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h0E));
    do_write(32'hDEADBEEF, 8'h00, pk8(7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h0E));
    wait_drain();

    lz = 1'b1;
    do_write(32'h00000A00, 8'hFF, pk8(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h08, 7'h40, 7'h40));
    do_write(32'h00000000, 8'hFF, pk8(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40));
    wait_drain();
    lz = 1'b0;

    do_write(32'h00004321, 8'hFF, pk8(7'h40, 7'h40, 7'h40, 7'h40, 7'h19, 7'h30, 7'h24, 7'h79));
    wait_drain();

    found = 1'b0;
    prev_sel = dig_sel;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (dig_sel == 8'h01 && prev_sel != 8'h01) found = 1'b1;
      prev_sel = dig_sel;
    end
    chk("scan_found_digit0", 64'(found), 64'd1);
    if (found) begin
      for (int c = 0; c < 27; c++) begin
        if (c > 0) @(negedge clk);
        chk("scan_dig_sel", dig_sel, 8'h01 << ((c / 3) % 8));
        chk("scan_seg_mux", seg_mux, mux_tab[(c / 3) % 8]);
      end
    end

    do_write(32'h00000005, 8'hFF, pk8(7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h12));
    wait_drain();
    blink_mask = 8'h01;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      bs0[i] = seg_o[6:0];
      bs1[i] = seg_o[13:7];
      @(negedge clk);
    end
    blink_mask = 8'h00;
    k = 0;
    for (int i = 4; i >= 1; i--) if (bs0[i] != bs0[i-1]) k = i;
    chk("blink_edge_found", 64'(k != 0), 64'd1);
    if (k != 0) begin
      chk("blink_val_legal", 64'(bs0[k] == 7'h12 || bs0[k] == 7'h7F), 64'd1);
      for (int j = 0; j < 8; j++)
        chk("blink_digit0", bs0[k+j],
            (j < 4) ? bs0[k] : ((bs0[k] == 7'h12) ? 7'h7F : 7'h12));
      chk("blink_period", bs0[k+8], bs0[k]);
    end
    for (int i = 0; i < 16; i++) chk("blink_digit1", bs1[i], 7'h40);

    b_lz = 1'b1;
    b_wr_en = 1'b1; b_wr_data = 16'h0008; b_wr_mask = 4'hF;
    @(negedge clk);
    b_wr_en = 1'b0;
    chk("b_wr_ack_high", b_wr_ack, 1'b1);
    @(negedge clk);
    chk("b_wr_ack_pulse", b_wr_ack, 1'b0);
    chk("b_seg_lz", b_seg, {7'h00, 7'h00, 7'h00, 7'h7F});
    b_lz = 1'b0;
    repeat (2) @(negedge clk);
    chk("b_seg_nolz", b_seg, {7'h3F, 7'h3F, 7'h3F, 7'h7F});

    wr_en = 1'b1; wr_data = 32'hFFFFFFFF; wr_mask = 8'hFF;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_wr_ack", wr_ack, 1'b0);
    chk("arst_seg_o", seg_o, {8{7'h40}});
    chk("arst_dig_sel", dig_sel, 8'h01);
    chk("arst_b_seg", b_seg, {4{7'h3F}});
    @(negedge clk);
    wr_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("arst_write_dropped", seg_o, {8{7'h40}});
    do_write(32'h00000009, 8'h01, pk8(7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h10));
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
